// File: rtl/neuron_mac_array.sv
// Multi-lane multiply-accumulate neuron core with a runtime-loadable weight RAM.
// Optional build macro NEURON_MAC_RELU_EN clamps negative results to zero after saturation.
module neuron_mac_array #(
    parameter int DATA_BITS   = 16,
    parameter int FRAC_BITS   = 8,
    parameter int NUM_WEIGHTS = 784,
    parameter int LANES       = 4,
    parameter int ACC_BITS    = 2*DATA_BITS + $clog2(NUM_WEIGHTS),
    localparam int BEATS      = NUM_WEIGHTS / LANES,
    localparam int AW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES*DATA_BITS-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [LANES*DATA_BITS-1:0] wr_data,
    input  logic [DATA_BITS-1:0]       bias,
    output logic [DATA_BITS-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int CW = AW + 1;
    localparam int PW = 2 * DATA_BITS;
    localparam int SW = ACC_BITS + 1;
    localparam logic [CW-1:0]        BEATS_C = CW'(BEATS);
    localparam logic signed [SW-1:0] MAX_V   = SW'(2**(DATA_BITS-1) - 1);
    localparam logic signed [SW-1:0] MIN_V   = SW'(-(2**(DATA_BITS-1)));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         flush_q, flush_d;
    logic signed [ACC_BITS-1:0]   acc_q, acc_d;
    logic                         v1_q, v2_q;
    logic signed [DATA_BITS-1:0]  in_q   [LANES];
    logic signed [PW-1:0]         prod_q [LANES];
    logic [LANES*DATA_BITS-1:0]   rd_q;
    logic [LANES*DATA_BITS-1:0]   wram   [BEATS];
    logic [DATA_BITS-1:0]         out_data_q;
    logic                         out_valid_q, busy_q, in_ready_q;

    logic                         accept_s, wr_ok_s, clear_s, load_out_s;
    logic                         in_ready_d;
    logic [AW-1:0]                rd_addr_s;
    logic signed [ACC_BITS-1:0]   sum_s;
    logic signed [SW-1:0]         s_s, bias_ext_s, r_s;
    logic [DATA_BITS-1:0]         sat_s, res_s;

    assign accept_s  = in_valid && in_ready_q;
    assign wr_ok_s   = wr_en && !busy_q && ({1'b0, wr_addr} < BEATS_C);
    assign rd_addr_s = cnt_q[AW-1:0];

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    // Weight RAM: writes only while idle, synchronous read at the current beat index.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            wram[wr_addr] <= wr_data;
        end
        if (accept_s) begin
            rd_q <= wram[rd_addr_s];
        end
    end

    // Input capture and per-lane multiply stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                in_q[i]   <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= accept_s;
            v2_q <= v1_q;
            for (int i = 0; i < LANES; i++) begin
                if (accept_s) begin
                    in_q[i] <= in_data[i*DATA_BITS +: DATA_BITS];
                end
                if (v1_q) begin
                    prod_q[i] <= in_q[i] * $signed(rd_q[i*DATA_BITS +: DATA_BITS]);
                end
            end
        end
    end

    // Adder tree and accumulator next value.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_s = sum_s + ACC_BITS'(prod_q[i]);
        end
        if (clear_s) begin
            acc_d = '0;
        end else if (v2_q) begin
            acc_d = acc_q + sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Bias add, rescale with floor rounding, saturate, optional ReLU.
    always_comb begin
        s_s        = SW'(acc_q);
        bias_ext_s = SW'($signed(bias)) <<< FRAC_BITS;
        s_s        = s_s + bias_ext_s;
        r_s        = s_s >>> FRAC_BITS;
        if (r_s > MAX_V) begin
            sat_s = MAX_V[DATA_BITS-1:0];
        end else if (r_s < MIN_V) begin
            sat_s = MIN_V[DATA_BITS-1:0];
        end else begin
            sat_s = r_s[DATA_BITS-1:0];
        end
`ifdef NEURON_MAC_RELU_EN
        if (sat_s[DATA_BITS-1]) begin
            res_s = {DATA_BITS{1'b0}};
        end else begin
            res_s = sat_s;
        end
`else
        res_s = sat_s;
`endif
    end

    // Sequencing: beat counting, two-cycle flush, output hold until accepted.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        clear_s    = 1'b0;
        load_out_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_ACCUM: begin
                if (cnt_q == BEATS_C) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end else if (accept_s) begin
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            ST_FLUSH: begin
                if (flush_q) begin
                    state_d    = ST_OUTPUT;
                    load_out_s = 1'b1;
                end else begin
                    flush_d    = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                clear_s = 1'b1;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE) || ((state_d == ST_ACCUM) && (cnt_d != BEATS_C));
    end

    // State, counters, accumulator and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            acc_q       <= acc_d;
            out_valid_q <= (state_d == ST_OUTPUT);
            busy_q      <= (state_d != ST_IDLE);
            in_ready_q  <= in_ready_d;
            if (load_out_s) begin
                out_data_q <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_array.sv
// Scoreboard bench for neuron_mac_array in a 2-lane, 4-weight configuration.
module tb_neuron_mac_array;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [0:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] bias;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    string       test_name = "reset";
    logic [15:0] exp_q [$];
    logic [15:0] w_m [4];
    logic [15:0] x_m [4];
    int          lat;

    neuron_mac_array #(
        .DATA_BITS   (16),
        .FRAC_BITS   (8),
        .NUM_WEIGHTS (4),
        .LANES       (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bias      (bias),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] b);
        longint acc, s, r;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += longint'($signed(x_m[k])) * longint'($signed(w_m[k]));
        end
        s = acc + longint'($signed(b)) * 256;
        r = s >>> 8;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`ifdef NEURON_MAC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[15:0];
    endfunction

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) check({test_name, "_sb_underflow"}, exp_q.size(), 1);
            else check({test_name, "_out_data"}, out_data, exp_q.pop_front());
        end
    end

    task automatic write_w(input logic [0:0] a, input logic [15:0] w0, input logic [15:0] w1,
                           input bit taken);
        wr_en = 1'b1; wr_addr = a; wr_data = {w1, w0};
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (taken) begin
            w_m[a*2]   = w0;
            w_m[a*2+1] = w1;
        end
    endtask

    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check({test_name, "_accept_timeout"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_neuron(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                               input logic [15:0] x3, input int gap, input logic [15:0] b);
        x_m[0] = x0; x_m[1] = x1; x_m[2] = x2; x_m[3] = x3;
        bias = b;
        exp_q.push_back(model_out(b));
        send_beat({x1, x0});
        repeat (gap) begin
            @(posedge clk); #1;
        end
        send_beat({x3, x2});
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (l < 40) begin
            @(posedge clk); #1;
            l++;
            if (out_valid) break;
        end
        if (!out_valid) check({test_name, "_valid_timeout"}, out_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check({test_name, "_idle_timeout"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; in_data = 32'd0; in_valid = 1'b0; wr_en = 1'b0; wr_addr = 1'b0;
        wr_data = 32'd0; bias = 16'd0; out_ready = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        write_w(1'b0, 16'h0100, 16'h0100, 1'b1);
        write_w(1'b1, 16'h0100, 16'h0100, 1'b1);

        test_name = "basic";
        send_neuron(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 16'h0000);
        check("basic_model", exp_q[0], 16'h0A00);
        wait_valid(lat);
        check("basic_latency", lat, 3);
        wait_idle();

        test_name = "bias_bubbles";
        send_neuron(16'h0100, 16'h0100, 16'h0100, 16'h0100, 2, 16'hFF00);
        check("bias_model", exp_q[0], 16'h0300);
        wait_valid(lat);
        check("bubbles_latency", lat, 3);
        wait_idle();

        test_name = "sat_pos";
        write_w(1'b0, 16'h7FFF, 16'h7FFF, 1'b1);
        write_w(1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
        send_neuron(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h0000);
        check("sat_pos_model", exp_q[0], 16'h7FFF);
        wait_valid(lat);
        wait_idle();

        test_name = "sat_neg";
        write_w(1'b0, 16'h8000, 16'h8000, 1'b1);
        write_w(1'b1, 16'h8000, 16'h8000, 1'b1);
        send_neuron(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h0000);
`ifdef NEURON_MAC_RELU_EN
        check("sat_neg_model", exp_q[0], 16'h0000);
`else
        check("sat_neg_model", exp_q[0], 16'h8000);
`endif
        wait_valid(lat);
        check("sat_neg_latency", lat, 3);
        wait_idle();

        test_name = "backpressure";
        write_w(1'b0, 16'h0100, 16'h0100, 1'b1);
        write_w(1'b1, 16'h0100, 16'h0100, 1'b1);
        out_ready = 1'b0;
        send_neuron(16'h0100, 16'h0200, 16'h0100, 16'h0300, 0, 16'h0000);
        write_w(1'b0, 16'h0200, 16'h0200, 1'b0);
        write_w(1'b1, 16'h0200, 16'h0200, 1'b0);
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, exp_q[0]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_idle();

        test_name = "lockout";
        send_neuron(16'h0100, 16'h0200, 16'h0100, 16'h0300, 0, 16'h0000);
        check("lockout_model", exp_q[0], 16'h0700);
        wait_valid(lat);
        wait_idle();

        test_name = "reset_mid";
        send_beat({16'h7000, 16'h7000});
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        send_neuron(16'h0200, 16'h0100, 16'h0100, 16'h0100, 0, 16'h0100);
        check("midrst_model", exp_q[0], 16'h0600);
        wait_valid(lat);
        check("midrst_latency", lat, 3);
        wait_idle();

        test_name = "random";
        for (int t = 0; t < 4; t++) begin
            write_w(1'b0, 16'($urandom), 16'($urandom), 1'b1);
            write_w(1'b1, 16'($urandom_range(0, 1023)), 16'($urandom_range(0, 1023)), 1'b1);
            send_neuron(16'($urandom), 16'($urandom_range(0, 511)), 16'($urandom),
                        16'($urandom_range(0, 511)), t, 16'($urandom));
            wait_valid(lat);
            check("random_latency", lat, 3 + ((t > 0) ? 0 : 0));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac_array.md
Name: neuron_mac_array

Overview:
- Parametrised multi-lane multiply-accumulate neuron core; successor to the single-lane weight multiplier.
- Per accepted beat: consumes LANES signed fixed-point inputs and multiplies each by its weight from an internal, runtime-loadable weight RAM.
- Accumulates over NUM_WEIGHTS/LANES beats, adds bias, rescales, saturates, and emits one neuron output over a valid/ready handshake.
- Sits between the layer input streamer and the activation/output collector.

Parameters:
- DATA_BITS, 16, width of inputs, weights, bias and output (signed, Q format).
- FRAC_BITS, 8, number of fractional bits in DATA_BITS values.
- NUM_WEIGHTS, 784, weights per neuron. Must be a multiple of LANES.
- LANES, 4, parallel multipliers per beat.
- ACC_BITS, 2*DATA_BITS+$clog2(NUM_WEIGHTS), accumulator width (signed).

Ports:
- clk  in  1  clock.
- reset  in  1  reset (asynchronous, active-high; clock clk).
- in_data  in  LANES*DATA_BITS  packed inputs; lane i occupies bits [i*DATA_BITS +: DATA_BITS].
- in_valid  in  1  input beat valid.
- in_ready  out  1  core accepts a beat.
- wr_en  in  1  weight RAM write strobe.
- wr_addr  in  $clog2(NUM_WEIGHTS/LANES)  beat index to write.
- wr_data  in  LANES*DATA_BITS  packed weights for that beat.
- bias  in  DATA_BITS  signed bias, sampled at the OUTPUT transition.
- out_data  out  DATA_BITS  saturated neuron result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Weight RAM:
  - BEATS = NUM_WEIGHTS/LANES words, each LANES*DATA_BITS wide, synchronous read.
  - Write takes effect when wr_en is high and busy=0.
  - Writes while busy=1 are dropped silently.
  - wr_addr >= BEATS is ignored.
  - RAM contents are not cleared by reset.
- FSM states: IDLE, ACCUM, FLUSH, OUTPUT.
  - IDLE: in_ready=1. The first accepted beat (in_valid&&in_ready) moves to ACCUM and counts as beat 0.
  - ACCUM: in_ready=1 until BEATS beats have been accepted. After the last beat, in_ready drops the next cycle and the FSM moves to FLUSH.
  - FLUSH: lasts exactly 2 cycles to drain the pipeline, then OUTPUT.
  - OUTPUT: out_valid=1; out_data is held stable until out_ready. On out_valid&&out_ready, go to IDLE, clear the accumulator, and reset the beat counter to 0.
- Bubbles: in_valid low during ACCUM inserts bubbles. The counter and accumulator hold, with no timeout.
- Pipeline (per accepted beat):
  - Edge 1: register inputs and issue RAM read at the beat counter address.
  - Edge 2: LANES signed products, each 2*DATA_BITS wide.
  - Edge 3: adder-tree sum sign-extended to ACC_BITS, added to the accumulator.
- Latency: out_valid rises 3 cycles after the edge that accepts the last beat. Back-to-back beats are accepted at 1 per cycle.
- Output arithmetic:
  - s = acc + (sign_ext(bias) <<< FRAC_BITS).
  - r = s >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
  - Saturate r to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
- Beat counter wraps only via the OUTPUT->IDLE transition, never mid-neuron.
- Reset (any state, including mid-accumulation):
  - FSM -> IDLE; accumulator, beat counter and pipeline valids -> 0.
  - Outputs: out_data=0, out_valid=0, busy=0, in_ready=1. in_ready is 1 in IDLE, including immediately after reset.
  - No partial result is emitted after reset.
- Simultaneous events: in OUTPUT, an in_valid is not accepted (in_ready=0). A new neuron starts at the earliest one cycle after the handshake.

Optional Feature:
- Macro NEURON_MAC_RELU_EN.
- Defined: after saturation, negative results are forced to 0 (ReLU), so out_data is always >= 0.
- Undefined: the signed saturated value is output unchanged.
- Latency is identical in both builds.

Test Plan:
- Config DATA_BITS=16, FRAC_BITS=8, NUM_WEIGHTS=4, LANES=2 for all tests below.
- Basic accumulate: all weights 0x0100, inputs {0x0100,0x0200} then {0x0300,0x0400}, bias 0 -> out_data=0x0A00; out_valid 3 cycles after the 2nd beat.
- Bias and bubbles: same weights, inputs all 0x0100 with 2 idle cycles between beats, bias 0xFF00 (-1.0) -> out_data=0x0300.
- Saturation:
  - Weights and inputs all 0x7FFF -> out_data=0x7FFF.
  - Weights 0x8000 with inputs 0x7FFF -> 0x8000 without the macro; 0x0000 with NUM_WEIGHTS... correction: 0x0000 with NEURON_MAC_RELU_EN.
- Backpressure and write lockout:
  - Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0.
  - A wr_en issued while busy is ignored; the next neuron uses the old weights.
- Reset mid-op: assert reset after 1 beat -> out_valid=0, busy=0, in_ready=1. A fresh 2-beat neuron then produces the correct result, uncontaminated by the aborted beat.
